// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder. The serial adder controller
// reuses this one cell for every bit position of an addition.
module fa_cell (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y,
    input  logic ci
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. It adds two WIDTH-bit operands
// plus a carry-in one bit per clock, LSB first, through a single fa_cell.
//
// Handshake: start is sampled only in IDLE. A start seen there at a rising edge
// captures a, b and cin and moves to RUN. busy is high for the whole of RUN.
// done pulses for exactly one cycle (the DONE state) when sum and cout become
// valid. sum and cout then hold until the next accepted start. No request is
// queued: start seen in RUN or DONE is dropped, but a start that is still high
// when IDLE is reached again is accepted at that edge.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter value at which the final (MSB) bit step happens.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic cell_s;
    logic cell_co;

    fa_cell u_fa (
        .s  (cell_s),
        .co (cell_co),
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry)
    );

    // Sequencer: state, datapath shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                    // One bit step: the cell's sum bit enters at the MSB so the
                    // LSB-first results end up in their natural positions.
                    sum_q <= {cell_s, sum_q[WIDTH-1:1]};
                    carry <= cell_co;
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        // Hold cnt here so it never wraps when WIDTH is a power of two.
                        cout_q <= cell_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    // Unreachable encoding: recover quietly to IDLE.
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: bench for serial_add_ctrl at WIDTH=8 and WIDTH=4, plus a
// standalone check of fa_cell. Expected results come from plain integer
// addition of the operands.
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    logic fx;
    logic fy;
    logic fci;
    logic fs;
    logic fco;

    int tests;
    int fails;
    int done_cnt8;
    int done_cnt4;

    logic [32:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    fa_cell u_fa_tb (
        .s  (fs),
        .co (fco),
        .x  (fx),
        .y  (fy),
        .ci (fci)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses (sampled before the edge updates them).
    always @(posedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done4 === 1'b1) done_cnt4++;
    end

    // Drive one WIDTH=8 operation; returns the result and the number of
    // negedges from the accepting edge until done was seen (bounded).
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output logic [7:0] os, output logic oc, output int lat);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        os = sum8;
        oc = cout8;
    endtask

    task automatic test_fa_cell();
        logic [1:0] exp2;
        for (int i = 0; i < 8; i++) begin
            fx = i[2]; fy = i[1]; fci = i[0];
            #1;
            exp2 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            tests++;
            if ({fco, fs} !== exp2) begin
                fails++;
                $display("FAIL fa_cell xyc=%0d: got co/s=%b%b, want %b", i, fco, fs, exp2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 8'h5A; b8 = 8'hA5; cin8 = 1;
        start4 = 0; a4 = 4'h5; b4 = 4'hA; cin4 = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            fails++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        tests++;
        if ({busy4, done4, sum4, cout4} !== 7'd0) begin
            fails++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b, want all 0", busy4, done4, sum4, cout4);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (done_cnt8 != 0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b dones=%0d, want 0/0", busy8, done_cnt8);
        end
    endtask

    task automatic test_basic_timing();
        logic [8:0] exp9;
        exp9 = 9'h3C + 9'h42;
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);   // edge k
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            tests++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                fails++;
                $display("FAIL basic_run cyc%0d: got busy=%b done=%b, want 1/0", j, busy8, done8);
            end
        end
        @(negedge clk);   // cycle after edge k+8
        tests++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: got busy=%b done=%b, want 0/1", busy8, done8);
        end
        tests++;
        if ({cout8, sum8} !== exp9) begin
            fails++;
            $display("FAIL basic_sum: got %h, want %h", {cout8, sum8}, exp9);
        end
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0 || {cout8, sum8} !== exp9) begin
            fails++;
            $display("FAIL basic_after: got done=%b result=%h, want 0/%h", done8, {cout8, sum8}, exp9);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        logic       tc[3];
        logic [7:0] os;
        logic       oc;
        logic [8:0] exp9;
        int         lat;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hA5; tb[1] = 8'h5A; tc[1] = 1'b1;
        ta[2] = 8'h00; tb[2] = 8'h00; tc[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp9 = 9'(ta[i]) + 9'(tb[i]) + 9'(tc[i]);
            run_op8(ta[i], tb[i], tc[i], os, oc, lat);
            tests++;
            if (lat != 9 || {oc, os} !== exp9) begin
                fails++;
                $display("FAIL carry%0d: got lat=%0d result=%h, want lat=9 result=%h", i, lat, {oc, os}, exp9);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int         d0;
        logic [8:0] exp9;
        exp9 = 9'h11 + 9'h22 + 9'h1;
        d0 = done_cnt8;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);   // edge k
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (j == 3) begin
                // Pulse a second request across edge k+3.
                a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
            end
            if (j == 9) begin
                tests++;
                if (done8 !== 1'b1 || {cout8, sum8} !== exp9) begin
                    fails++;
                    $display("FAIL ignore_done: got done=%b result=%h, want 1/%h", done8, {cout8, sum8}, exp9);
                end
            end
        end
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            tests++;
            if (done8 !== 1'b0 || {cout8, sum8} !== exp9) begin
                fails++;
                $display("FAIL ignore_hold%0d: got done=%b result=%h, want 0/%h", j, done8, {cout8, sum8}, exp9);
            end
        end
        tests++;
        if (done_cnt8 - d0 != 1) begin
            fails++;
            $display("FAIL ignore_count: got %0d dones, want 1", done_cnt8 - d0);
        end
    endtask

    task automatic test_reset_mid_run();
        int         d0;
        logic [7:0] os;
        logic       oc;
        int         lat;
        d0 = done_cnt8;
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h88; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);   // edge k
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);   // edge k+4
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy8, done8, sum8, cout8} !== 11'd0 || dut8.state !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b state=%0d, want 0s/IDLE",
                     busy8, done8, sum8, cout8, dut8.state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tests++;
        if (done_cnt8 != d0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nodone: got %0d dones busy=%b, want 0/0", done_cnt8 - d0, busy8);
        end
        run_op8(8'h10, 8'h20, 1'b0, os, oc, lat);
        tests++;
        if (lat != 9 || {oc, os} !== 9'h030) begin
            fails++;
            $display("FAIL reset_mid_recover: got lat=%0d result=%h, want lat=9 result=030", lat, {oc, os});
        end
        @(negedge clk);
    endtask

    // Back-to-back: start stays high, so a new operation is accepted every w+2 cycles.
    task automatic test_back_to_back(input int w, input int n);
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        logic [32:0] mask;
        logic [32:0] e;
        logic [32:0] obs;
        logic [32:0] want;
        logic        dn;
        logic        bz;
        int          d0;
        mask = (33'd1 << (w + 1)) - 33'd1;
        d0 = (w == 8) ? done_cnt8 : done_cnt4;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ra = $urandom_range(0, (1 << w) - 1);
            rb = $urandom_range(0, (1 << w) - 1);
            rc = $urandom_range(0, 1);
            if (w == 8) begin
                a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc[0]; start8 = 1'b1;
            end else begin
                a4 = ra[3:0]; b4 = rb[3:0]; cin4 = rc[0]; start4 = 1'b1;
            end
            e = (33'(ra) + 33'(rb) + 33'(rc)) & mask;
            exp_q.push_back(e);
            for (int j = 1; j <= w + 1; j++) begin
                @(negedge clk);
                if (j == 2) begin
                    // Scramble inputs after capture; the result must not move.
                    if (w == 8) begin
                        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                    end else begin
                        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
                    end
                end
                dn  = (w == 8) ? done8 : done4;
                bz  = (w == 8) ? busy8 : busy4;
                obs = (w == 8) ? 33'({cout8, sum8}) : 33'({cout4, sum4});
                if (j <= w) begin
                    tests++;
                    if (bz !== 1'b1 || dn !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b_w%0d op%0d cyc%0d: got busy=%b done=%b, want 1/0", w, i, j, bz, dn);
                    end
                end else begin
                    want = exp_q.pop_front();
                    tests++;
                    if (dn !== 1'b1 || bz !== 1'b0 || obs !== want) begin
                        fails++;
                        $display("FAIL b2b_w%0d op%0d: got done=%b busy=%b result=%h, want 1/0/%h",
                                 w, i, dn, bz, obs, want);
                    end
                end
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        start4 = 1'b0;
        repeat (w + 4) @(negedge clk);
        tests++;
        if (((w == 8) ? done_cnt8 : done_cnt4) - d0 != n) begin
            fails++;
            $display("FAIL b2b_w%0d_count: got %0d dones, want %0d", w,
                     ((w == 8) ? done_cnt8 : done_cnt4) - d0, n);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done_cnt8 = 0;
        done_cnt4 = 0;
        fx = 0; fy = 0; fci = 0;
        test_fa_cell();
        test_reset();
        test_basic_timing();
        test_carry();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back(8, 200);
        test_back_to_back(4, 200);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
